// File: rtl/serv_memchk_pkg.sv
// Shared types for the SERV load/store retirement checker.
// Optional feature macro: SERV_MEMCHK_DATA_EN adds write/read data fields to
// each queued bus transaction so the checker can also compare data lanes.
package serv_memchk_pkg;

    // Error codes. When several fire in one cycle the lowest value is latched.
    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_SPUR_ACK = 4'd1,
        ERR_ABORT    = 4'd2,
        ERR_UNSTABLE = 4'd3,
        ERR_OVERFLOW = 4'd4,
        ERR_NO_TXN   = 4'd5,
        ERR_ORPHAN   = 4'd6,
        ERR_MISALIGN = 4'd7,
        ERR_BAD_TRAP = 4'd8,
        ERR_ADDR     = 4'd9,
        ERR_BUS_ADR  = 4'd10,
        ERR_MASK     = 4'd11,
        ERR_DIR      = 4'd12,
        ERR_WDATA    = 4'd13,
        ERR_RDATA    = 4'd14
    } err_e;

    // Highest error code in use; the error vector is indexed by code.
    localparam int ERR_MAX = 14;

    // Bus-side tracking of a single data-bus cycle.
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_WAIT = 1'b1
    } bus_state_e;

    // Major opcode field (insn[6:2]) of loads and stores.
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    // One completed data-bus transaction as seen on the wishbone-style bus.
    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
`ifdef SERV_MEMCHK_DATA_EN
        logic [31:0] dat;
        logic [31:0] rdt;
`endif
    } txn_t;

    // Byte-lane mask for an access of the given size (funct3[1:0]) at the
    // given byte offset within the word.
    function automatic logic [3:0] exp_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/serv_memchk_fifo.sv
// Pending-transaction queue for the SERV memory checker. Holds bus
// transactions between their acknowledge and the matching retirement.
// A push while full is dropped unless a pop happens in the same cycle.
module serv_memchk_fifo
    import serv_memchk_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  txn_t                   i_data,
    input  logic                   i_pop,
    output txn_t                   o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    txn_t               r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W:0]     r_level;
    logic               w_doPush;
    logic               w_doPop;

    assign o_empty  = (r_level == '0);
    assign o_full   = (r_level == FULL_LEVEL);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_head   = r_mem[r_rdPtr];
    assign o_level  = r_level;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/serv_memchk_monitor.sv
// Passive checker that pairs SERV data-bus transactions with RVFI load/store
// retirements and reports the first protocol or consistency violation.
// Optional feature macro: SERV_MEMCHK_DATA_EN enables store/load data checks.
module serv_memchk_monitor
    import serv_memchk_pkg::*;
#(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] ADDR_LIMIT = 32'h80000000,
    parameter int          CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_dbus_ack,
    input  logic [31:0]            i_dbus_rdt,
    input  logic [31:0]            o_dbus_adr,
    input  logic [31:0]            o_dbus_dat,
    input  logic [3:0]             o_dbus_sel,
    input  logic                   o_dbus_we,
    input  logic                   o_dbus_cyc,
    input  logic                   rvfi_valid,
    input  logic                   rvfi_trap,
    input  logic [31:0]            rvfi_insn,
    input  logic [31:0]            rvfi_rs1_rdata,
    input  logic [31:0]            rvfi_rs2_rdata,
    input  logic [31:0]            rvfi_mem_addr,
    input  logic [31:0]            rvfi_mem_rdata,
    input  logic [31:0]            rvfi_mem_wdata,
    input  logic [3:0]             rvfi_mem_rmask,
    input  logic [3:0]             rvfi_mem_wmask,
    output logic                   o_err,
    output logic [3:0]             o_err_code,
    output logic [CNT_W-1:0]       o_chk_cnt,
    output logic [CNT_W-1:0]       o_err_cnt,
    output logic [$clog2(DEPTH):0] o_q_level
);

    bus_state_e       r_busState;
    logic [31:0]      r_adr;
    logic [31:0]      r_dat;
    logic [3:0]       r_sel;
    logic             r_we;

    logic             r_err;
    err_e             r_errCode;
    logic [CNT_W-1:0] r_chkCnt;
    logic [CNT_W-1:0] r_errCnt;

    txn_t             w_ackTxn;
    txn_t             w_head;
    txn_t             w_cmp;
    logic             w_ackValid;
    logic             w_fifoFull;
    logic             w_fifoEmpty;
    logic             w_push;
    logic             w_pop;
    logic             w_useBypass;
    logic             w_haveTxn;

    logic [4:0]       w_opcode;
    logic [1:0]       w_size;
    logic             w_isLoad;
    logic             w_isStore;
    logic             w_isMem;
    logic [31:0]      w_imm;
    logic [31:0]      w_effAddr;
    logic             w_misaligned;
    logic             w_trapReq;
    logic             w_doCheck;
    logic [3:0]       w_expMask;
    logic [3:0]       w_usedMask;
    logic [3:0]       w_otherMask;
    logic             w_wdataErr;
    logic             w_rdataErr;

    logic [ERR_MAX:0] w_errVec;
    logic             w_anyErr;
    err_e             w_firstErr;

    // Bus FSM: track one cycle from cyc to ack and remember the request
    // fields so changes while waiting can be spotted. Reset drops any cycle in flight.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busState <= BUS_IDLE;
            r_adr      <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_we       <= 1'b0;
        end else begin
            case (r_busState)
                BUS_IDLE: begin
                    if (o_dbus_cyc) begin
                        r_busState <= BUS_WAIT;
                        r_adr      <= o_dbus_adr;
                        r_dat      <= o_dbus_dat;
                        r_sel      <= o_dbus_sel;
                        r_we       <= o_dbus_we;
                    end
                end
                BUS_WAIT: begin
                    if (i_dbus_ack || !o_dbus_cyc) begin
                        r_busState <= BUS_IDLE;
                    end else begin
                        r_adr <= o_dbus_adr;
                        r_dat <= o_dbus_dat;
                        r_sel <= o_dbus_sel;
                        r_we  <= o_dbus_we;
                    end
                end
                default: r_busState <= BUS_IDLE;
            endcase
        end
    end

    assign w_ackValid = (r_busState == BUS_WAIT) && i_dbus_ack;

    // Transaction formed from the bus signals at the moment of acknowledge.
    always_comb begin
        w_ackTxn     = '0;
        w_ackTxn.adr = o_dbus_adr;
        w_ackTxn.sel = o_dbus_sel;
        w_ackTxn.we  = o_dbus_we;
`ifdef SERV_MEMCHK_DATA_EN
        w_ackTxn.dat = o_dbus_dat;
        w_ackTxn.rdt = i_dbus_rdt;
`endif
    end

    // Instruction decode and effective-address computation for the retirement.
    always_comb begin
        w_opcode  = rvfi_insn[6:2];
        w_size    = rvfi_insn[13:12];
        w_isLoad  = rvfi_valid && (w_opcode == OP_LOAD);
        w_isStore = rvfi_valid && (w_opcode == OP_STORE);
        w_isMem   = w_isLoad || w_isStore;
        if (w_isStore) begin
            w_imm = {{20{rvfi_insn[31]}}, rvfi_insn[31:25], rvfi_insn[11:7]};
        end else begin
            w_imm = {{20{rvfi_insn[31]}}, rvfi_insn[31:20]};
        end
        w_effAddr    = rvfi_rs1_rdata + w_imm;
        w_misaligned = ((w_size == 2'b01) && w_effAddr[0]) ||
                       ((w_size == 2'b10) && (w_effAddr[1:0] != 2'b00));
        w_trapReq    = w_misaligned || (w_effAddr >= ADDR_LIMIT);
        w_doCheck    = w_isMem && !w_trapReq && !rvfi_trap;
        w_expMask    = exp_mask(w_size, w_effAddr[1:0]);
        w_usedMask   = w_isLoad ? rvfi_mem_rmask : rvfi_mem_wmask;
        w_otherMask  = w_isLoad ? rvfi_mem_wmask : rvfi_mem_rmask;
    end

    // A check against an empty queue may use the transaction being acked right now.
    assign w_useBypass = w_doCheck && w_fifoEmpty && w_ackValid;
    assign w_haveTxn   = !w_fifoEmpty || w_ackValid;
    assign w_cmp       = w_fifoEmpty ? w_ackTxn : w_head;
    assign w_push      = w_ackValid && !w_useBypass;
    assign w_pop       = w_doCheck && !w_fifoEmpty;

`ifdef SERV_MEMCHK_DATA_EN
    logic [31:0] w_expData;
    logic [31:0] w_laneMask;

    // Store data replicated across lanes by access width, compared only where the mask enables.
    always_comb begin
        case (w_size)
            2'b00:   w_expData = {4{rvfi_rs2_rdata[7:0]}};
            2'b01:   w_expData = {2{rvfi_rs2_rdata[15:0]}};
            default: w_expData = rvfi_rs2_rdata;
        endcase
        w_laneMask = {{8{w_expMask[3]}}, {8{w_expMask[2]}}, {8{w_expMask[1]}}, {8{w_expMask[0]}}};
        w_wdataErr = w_doCheck && w_isStore &&
                     ((w_haveTxn && (((w_cmp.dat ^ w_expData) & w_laneMask) != '0)) ||
                      (((rvfi_mem_wdata ^ w_expData) & w_laneMask) != '0));
        w_rdataErr = w_doCheck && w_isLoad && w_haveTxn && (rvfi_mem_rdata != w_cmp.rdt);
    end

    logic w_unusedBits;
    assign w_unusedBits = ^{rvfi_insn[19:14]};
`else
    assign w_wdataErr = 1'b0;
    assign w_rdataErr = 1'b0;

    logic w_unusedBits;
    assign w_unusedBits = ^{rvfi_insn[19:14], rvfi_rs2_rdata, rvfi_mem_rdata,
                            rvfi_mem_wdata, i_dbus_rdt};
`endif

    // Collect every violation of this cycle and pick the lowest code.
    always_comb begin
        w_errVec               = '0;
        w_errVec[ERR_SPUR_ACK] = (r_busState == BUS_IDLE) && i_dbus_ack;
        w_errVec[ERR_ABORT]    = (r_busState == BUS_WAIT) && !o_dbus_cyc && !i_dbus_ack;
        w_errVec[ERR_UNSTABLE] = (r_busState == BUS_WAIT) && o_dbus_cyc &&
                                 ((o_dbus_adr != r_adr) || (o_dbus_sel != r_sel) ||
                                  (o_dbus_we != r_we) || (o_dbus_dat != r_dat));
        w_errVec[ERR_OVERFLOW] = w_push && w_fifoFull && !w_pop;
        w_errVec[ERR_NO_TXN]   = w_doCheck && !w_haveTxn;
        w_errVec[ERR_ORPHAN]   = rvfi_valid && (!w_isMem || rvfi_trap) && !w_fifoEmpty;
        w_errVec[ERR_MISALIGN] = w_isMem && w_trapReq && !rvfi_trap;
        w_errVec[ERR_BAD_TRAP] = w_isMem && !w_trapReq && rvfi_trap;
        w_errVec[ERR_ADDR]     = w_doCheck && (rvfi_mem_addr != w_effAddr);
        w_errVec[ERR_BUS_ADR]  = w_doCheck && w_haveTxn && (w_cmp.adr != {w_effAddr[31:2], 2'b00});
        w_errVec[ERR_MASK]     = w_doCheck && ((w_usedMask != w_expMask) || (w_otherMask != 4'b0000) ||
                                               (w_haveTxn && (w_cmp.sel != w_expMask)));
        w_errVec[ERR_DIR]      = w_doCheck && w_haveTxn && (w_cmp.we != w_isStore);
        w_errVec[ERR_WDATA]    = w_wdataErr;
        w_errVec[ERR_RDATA]    = w_rdataErr;
        w_anyErr   = |w_errVec;
        w_firstErr = ERR_NONE;
        for (int i = ERR_MAX; i >= 1; i--) begin
            if (w_errVec[i]) begin
                w_firstErr = err_e'(i[3:0]);
            end
        end
    end

    // Saturating counters plus sticky flag and first-error code.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err     <= 1'b0;
            r_errCode <= ERR_NONE;
            r_chkCnt  <= '0;
            r_errCnt  <= '0;
        end else begin
            if (w_doCheck && (r_chkCnt != '1)) begin
                r_chkCnt <= r_chkCnt + 1'b1;
            end
            if (w_anyErr) begin
                if (r_errCnt != '1) begin
                    r_errCnt <= r_errCnt + 1'b1;
                end
                if (!r_err) begin
                    r_err     <= 1'b1;
                    r_errCode <= w_firstErr;
                end
            end
        end
    end

    serv_memchk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_ackTxn),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_level (o_q_level),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    assign o_err      = r_err;
    assign o_err_code = r_errCode;
    assign o_chk_cnt  = r_chkCnt;
    assign o_err_cnt  = r_errCnt;

endmodule

// File: tb/tb_serv_memchk_monitor.sv
// Directed bench for serv_memchk_monitor: bus/retire scenarios with hand-computed expectations.
module tb_serv_memchk_monitor;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_dbus_ack;
    logic [31:0] i_dbus_rdt;
    logic [31:0] o_dbus_adr;
    logic [31:0] o_dbus_dat;
    logic [3:0]  o_dbus_sel;
    logic        o_dbus_we;
    logic        o_dbus_cyc;
    logic        rvfi_valid;
    logic        rvfi_trap;
    logic [31:0] rvfi_insn;
    logic [31:0] rvfi_rs1_rdata;
    logic [31:0] rvfi_rs2_rdata;
    logic [31:0] rvfi_mem_addr;
    logic [31:0] rvfi_mem_rdata;
    logic [31:0] rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask;
    logic [3:0]  rvfi_mem_wmask;
    logic        o_err;
    logic [3:0]  o_err_code;
    logic [CNT_W-1:0] o_chk_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [$clog2(DEPTH):0] o_q_level;

    int totalChecks = 0;
    int badChecks   = 0;

    serv_memchk_monitor #(
        .DEPTH      (DEPTH),
        .ADDR_LIMIT (32'h80000000),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_dbus_ack     (i_dbus_ack),
        .i_dbus_rdt     (i_dbus_rdt),
        .o_dbus_adr     (o_dbus_adr),
        .o_dbus_dat     (o_dbus_dat),
        .o_dbus_sel     (o_dbus_sel),
        .o_dbus_we      (o_dbus_we),
        .o_dbus_cyc     (o_dbus_cyc),
        .rvfi_valid     (rvfi_valid),
        .rvfi_trap      (rvfi_trap),
        .rvfi_insn      (rvfi_insn),
        .rvfi_rs1_rdata (rvfi_rs1_rdata),
        .rvfi_rs2_rdata (rvfi_rs2_rdata),
        .rvfi_mem_addr  (rvfi_mem_addr),
        .rvfi_mem_rdata (rvfi_mem_rdata),
        .rvfi_mem_wdata (rvfi_mem_wdata),
        .rvfi_mem_rmask (rvfi_mem_rmask),
        .rvfi_mem_wmask (rvfi_mem_wmask),
        .o_err          (o_err),
        .o_err_code     (o_err_code),
        .o_chk_cnt      (o_chk_cnt),
        .o_err_cnt      (o_err_cnt),
        .o_q_level      (o_q_level)
    );

    always #5 clk = ~clk;

    // Load: rd=x5, rs1=x1; store: rs2=x2, rs1=x1.
    function automatic logic [31:0] loadInsn(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd5, 7'b0000011};
    endfunction

    function automatic logic [31:0] storeInsn(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        i_dbus_ack = 0; i_dbus_rdt = 0; o_dbus_adr = 0; o_dbus_dat = 0; o_dbus_sel = 0;
        o_dbus_we = 0; o_dbus_cyc = 0; rvfi_valid = 0; rvfi_trap = 0; rvfi_insn = 0;
        rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_mem_addr = 0; rvfi_mem_rdata = 0;
        rvfi_mem_wdata = 0; rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
    endtask

    task automatic doReset();
        clearInputs();
        i_rst_n = 0;
        step();
        i_rst_n = 1;
        step();
    endtask

    // cyc cycle, then ack cycle; cyc drops right after the acking edge.
    task automatic busTxn(input logic [31:0] adr, input logic [3:0] sel, input logic we,
                          input logic [31:0] dat, input logic [31:0] rdt);
        o_dbus_cyc = 1; o_dbus_adr = adr; o_dbus_sel = sel; o_dbus_we = we; o_dbus_dat = dat;
        step();
        i_dbus_ack = 1; i_dbus_rdt = rdt;
        step();
        i_dbus_ack = 0; o_dbus_cyc = 0;
    endtask

    task automatic setRetire(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [31:0] maddr, input logic [31:0] rdata, input logic [31:0] wdata,
                             input logic [3:0] rmask, input logic [3:0] wmask, input logic trap);
        rvfi_valid = 1; rvfi_insn = insn; rvfi_rs1_rdata = rs1; rvfi_rs2_rdata = rs2;
        rvfi_mem_addr = maddr; rvfi_mem_rdata = rdata; rvfi_mem_wdata = wdata;
        rvfi_mem_rmask = rmask; rvfi_mem_wmask = wmask; rvfi_trap = trap;
    endtask

    task automatic retire(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] maddr, input logic [31:0] rdata, input logic [31:0] wdata,
                          input logic [3:0] rmask, input logic [3:0] wmask, input logic trap);
        setRetire(insn, rs1, rs2, maddr, rdata, wdata, rmask, wmask, trap);
        step();
        rvfi_valid = 0; rvfi_trap = 0;
    endtask

    task automatic test_reset();
        doReset();
        i_dbus_ack = 1;
        step();
        i_dbus_ack = 0;
        doReset();
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL reset_err: got %0d want 0", o_err); end
        totalChecks++; if (o_err_code !== 4'd0) begin badChecks++; $display("[TB] FAIL reset_code: got %0d want 0", o_err_code); end
        totalChecks++; if (o_chk_cnt !== 4'd0) begin badChecks++; $display("[TB] FAIL reset_chk: got %0d want 0", o_chk_cnt); end
        totalChecks++; if (o_err_cnt !== 4'd0) begin badChecks++; $display("[TB] FAIL reset_errcnt: got %0d want 0", o_err_cnt); end
        totalChecks++; if (o_q_level !== 2'd0) begin badChecks++; $display("[TB] FAIL reset_level: got %0d want 0", o_q_level); end
    endtask

    task automatic test_load_word();
        doReset();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF);
        totalChecks++; if (o_q_level !== 2'd1) begin badChecks++; $display("[TB] FAIL lw_level_push: got %0d want 1", o_q_level); end
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_chk_cnt !== 4'd1) begin badChecks++; $display("[TB] FAIL lw_chk: got %0d want 1", o_chk_cnt); end
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL lw_err: got %0d want 0 (code %0d)", o_err, o_err_code); end
        totalChecks++; if (o_q_level !== 2'd0) begin badChecks++; $display("[TB] FAIL lw_level_pop: got %0d want 0", o_q_level); end
    endtask

    task automatic test_store_byte();
        doReset();
        busTxn(32'h200, 4'h8, 1'b1, 32'hA5A5A5A5, 32'h0);
        retire(storeInsn(12'd3, 3'b000), 32'h200, 32'hA5, 32'h203, 32'h0, 32'hA5A5A5A5, 4'h0, 4'h8, 1'b0);
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL sb_pass_err: got %0d want 0 (code %0d)", o_err, o_err_code); end
        totalChecks++; if (o_chk_cnt !== 4'd1) begin badChecks++; $display("[TB] FAIL sb_pass_chk: got %0d want 1", o_chk_cnt); end
        busTxn(32'h200, 4'h4, 1'b1, 32'hA5A5A5A5, 32'h0);
        retire(storeInsn(12'd3, 3'b000), 32'h200, 32'hA5, 32'h203, 32'h0, 32'hA5A5A5A5, 4'h0, 4'h8, 1'b0);
        totalChecks++; if (o_err_code !== 4'd11) begin badChecks++; $display("[TB] FAIL sb_mask_code: got %0d want 11", o_err_code); end
        totalChecks++; if (o_err_cnt !== 4'd1) begin badChecks++; $display("[TB] FAIL sb_mask_errcnt: got %0d want 1", o_err_cnt); end
        totalChecks++; if (o_chk_cnt !== 4'd2) begin badChecks++; $display("[TB] FAIL sb_mask_chk: got %0d want 2", o_chk_cnt); end
    endtask

    task automatic test_misalign();
        doReset();
        retire(loadInsn(12'd0, 3'b001), 32'h101, 32'h0, 32'h101, 32'h0, 32'h0, 4'h0, 4'h0, 1'b1);
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL lh_trap_err: got %0d want 0 (code %0d)", o_err, o_err_code); end
        totalChecks++; if (o_q_level !== 2'd0) begin badChecks++; $display("[TB] FAIL lh_trap_level: got %0d want 0", o_q_level); end
        totalChecks++; if (o_chk_cnt !== 4'd0) begin badChecks++; $display("[TB] FAIL lh_trap_chk: got %0d want 0", o_chk_cnt); end
        retire(loadInsn(12'd0, 3'b001), 32'h101, 32'h0, 32'h101, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0);
        totalChecks++; if (o_err_code !== 4'd7) begin badChecks++; $display("[TB] FAIL lh_notrap_code: got %0d want 7", o_err_code); end
        // Aligned word above the legal range also demands a trap.
        doReset();
        retire(loadInsn(12'd8, 3'b010), 32'h80000000, 32'h0, 32'h80000008, 32'h0, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_err_code !== 4'd7) begin badChecks++; $display("[TB] FAIL limit_code: got %0d want 7", o_err_code); end
    endtask

    task automatic test_back_to_back();
        doReset();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h1);
        totalChecks++; if (o_q_level !== 2'd1) begin badChecks++; $display("[TB] FAIL b2b_level1: got %0d want 1", o_q_level); end
        busTxn(32'h208, 4'hF, 1'b0, 32'h0, 32'h2);
        totalChecks++; if (o_q_level !== 2'd2) begin badChecks++; $display("[TB] FAIL b2b_level2: got %0d want 2", o_q_level); end
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h1, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_q_level !== 2'd1) begin badChecks++; $display("[TB] FAIL b2b_pop1: got %0d want 1", o_q_level); end
        retire(loadInsn(12'd8, 3'b010), 32'h200, 32'h0, 32'h208, 32'h2, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_q_level !== 2'd0) begin badChecks++; $display("[TB] FAIL b2b_pop2: got %0d want 0", o_q_level); end
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL b2b_err: got %0d want 0 (code %0d)", o_err, o_err_code); end
        totalChecks++; if (o_chk_cnt !== 4'd2) begin badChecks++; $display("[TB] FAIL b2b_chk: got %0d want 2", o_chk_cnt); end
        for (int i = 0; i < 3; i++) begin
            busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h0);
        end
        totalChecks++; if (o_q_level !== 2'd2) begin badChecks++; $display("[TB] FAIL ovf_level: got %0d want 2", o_q_level); end
        totalChecks++; if (o_err_code !== 4'd4) begin badChecks++; $display("[TB] FAIL ovf_code: got %0d want 4", o_err_code); end
    endtask

    task automatic test_bypass();
        doReset();
        o_dbus_cyc = 1; o_dbus_adr = 32'h108; o_dbus_sel = 4'hF; o_dbus_we = 0;
        step();
        i_dbus_ack = 1; i_dbus_rdt = 32'h55AA;
        setRetire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h55AA, 32'h0, 4'hF, 4'h0, 1'b0);
        step();
        clearInputs();
        step();
        totalChecks++; if (o_q_level !== 2'd0) begin badChecks++; $display("[TB] FAIL bypass_level: got %0d want 0", o_q_level); end
        totalChecks++; if (o_chk_cnt !== 4'd1) begin badChecks++; $display("[TB] FAIL bypass_chk: got %0d want 1", o_chk_cnt); end
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL bypass_err: got %0d want 0 (code %0d)", o_err, o_err_code); end
    endtask

    task automatic test_reset_midcycle();
        doReset();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h7);
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h7, 32'h0, 4'hF, 4'h0, 1'b0);
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h7);
        o_dbus_cyc = 1; o_dbus_adr = 32'h300; o_dbus_sel = 4'hF;
        step();
        #2;
        i_rst_n = 0;
        clearInputs();
        #1;
        totalChecks++; if (o_q_level !== 2'd0) begin badChecks++; $display("[TB] FAIL rstmid_level: got %0d want 0", o_q_level); end
        totalChecks++; if (o_chk_cnt !== 4'd0) begin badChecks++; $display("[TB] FAIL rstmid_chk: got %0d want 0", o_chk_cnt); end
        step();
        i_rst_n = 1;
        step();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h9);
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h9, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_chk_cnt !== 4'd1) begin badChecks++; $display("[TB] FAIL rstmid_after_chk: got %0d want 1", o_chk_cnt); end
        totalChecks++; if (o_err !== 1'b0) begin badChecks++; $display("[TB] FAIL rstmid_after_err: got %0d want 0 (code %0d)", o_err, o_err_code); end
    endtask

    task automatic test_bus_protocol();
        doReset();
        i_dbus_ack = 1;
        step();
        i_dbus_ack = 0;
        totalChecks++; if (o_err_code !== 4'd1) begin badChecks++; $display("[TB] FAIL spur_code: got %0d want 1", o_err_code); end
        doReset();
        o_dbus_cyc = 1;
        step();
        o_dbus_cyc = 0;
        step();
        totalChecks++; if (o_err_code !== 4'd2) begin badChecks++; $display("[TB] FAIL abort_code: got %0d want 2", o_err_code); end
        doReset();
        o_dbus_cyc = 1; o_dbus_adr = 32'h108; o_dbus_sel = 4'hF;
        step();
        o_dbus_adr = 32'h10C;
        step();
        totalChecks++; if (o_err_code !== 4'd3) begin badChecks++; $display("[TB] FAIL unstable_code: got %0d want 3", o_err_code); end
        clearInputs();
        // Error counter saturates at all-ones with a continuous spurious ack.
        doReset();
        i_dbus_ack = 1;
        for (int i = 0; i < 20; i++) step();
        i_dbus_ack = 0;
        totalChecks++; if (o_err_cnt !== 4'hF) begin badChecks++; $display("[TB] FAIL errcnt_sat: got %0d want 15", o_err_cnt); end
    endtask

    task automatic test_retire_errors();
        // Non-memory retire with a pending txn leaves the queue alone.
        doReset();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h0);
        retire({12'd1, 5'd1, 3'b000, 5'd1, 7'b0010011}, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0);
        totalChecks++; if (o_err_code !== 4'd6) begin badChecks++; $display("[TB] FAIL orphan_code: got %0d want 6", o_err_code); end
        totalChecks++; if (o_q_level !== 2'd1) begin badChecks++; $display("[TB] FAIL orphan_level: got %0d want 1", o_q_level); end
        doReset();
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h0, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_err_code !== 4'd5) begin badChecks++; $display("[TB] FAIL notxn_code: got %0d want 5", o_err_code); end
        doReset();
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h0, 32'h0, 4'hF, 4'h0, 1'b1);
        totalChecks++; if (o_err_code !== 4'd8) begin badChecks++; $display("[TB] FAIL badtrap_code: got %0d want 8", o_err_code); end
        doReset();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h3);
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h10C, 32'h3, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_err_code !== 4'd9) begin badChecks++; $display("[TB] FAIL addr_code: got %0d want 9", o_err_code); end
        doReset();
        busTxn(32'h10C, 4'hF, 1'b0, 32'h0, 32'h3);
        retire(loadInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h3, 32'h0, 4'hF, 4'h0, 1'b0);
        totalChecks++; if (o_err_code !== 4'd10) begin badChecks++; $display("[TB] FAIL busadr_code: got %0d want 10", o_err_code); end
        doReset();
        busTxn(32'h108, 4'hF, 1'b0, 32'h0, 32'h0);
        retire(storeInsn(12'd8, 3'b010), 32'h100, 32'h0, 32'h108, 32'h0, 32'h0, 4'h0, 4'hF, 1'b0);
        totalChecks++; if (o_err_code !== 4'd12) begin badChecks++; $display("[TB] FAIL dir_code: got %0d want 12", o_err_code); end
    endtask

    initial begin
        i_rst_n = 1;
        clearInputs();
        test_reset();
        test_load_word();
        test_store_byte();
        test_misalign();
        test_back_to_back();
        test_bypass();
        test_reset_midcycle();
        test_bus_protocol();
        test_retire_errors();
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
